hex_digit_scanner: RTL and testbench

Time-multiplexed scan controller for a bank of seven-segment digits. It holds a multi-nibble display value, commits new values only at frame boundaries so the display never tears, and steps through the digits one at a time. For each digit it presents one nibble plus a one-hot digit enable, and this nibble drives the downstream hex-to-segment decoder. A guard interval between digits suppresses ghosting.

---
 rtl/hex_digit_scanner_if.sv | 27 ++
 rtl/hex_digit_scanner.sv | 130 +++++++++++++
 tb/tb_hex_digit_scanner.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/hex_digit_scanner_if.sv
// Bus bundle between a display-value producer and hex_digit_scanner.
// Optional feature macro: HEX_SCAN_LZB_EN adds the blank_zero_i signal.
interface hex_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    load_en_i;
`ifdef HEX_SCAN_LZB_EN
    logic                    blank_zero_i;
`endif
    logic [3:0]              nibble_o;
    logic [NUM_DIGITS-1:0]   digit_sel_o;
    logic                    digit_blank_o;
    logic                    frame_done_o;

`ifdef HEX_SCAN_LZB_EN
    modport master (output value_i, load_en_i, blank_zero_i,
                    input  nibble_o, digit_sel_o, digit_blank_o, frame_done_o);
    modport slave  (input  value_i, load_en_i, blank_zero_i,
                    output nibble_o, digit_sel_o, digit_blank_o, frame_done_o);
`else
    modport master (output value_i, load_en_i,
                    input  nibble_o, digit_sel_o, digit_blank_o, frame_done_o);
    modport slave  (input  value_i, load_en_i,
                    output nibble_o, digit_sel_o, digit_blank_o, frame_done_o);
`endif
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed seven-segment scan controller with tear-free frame commits.
// Each digit slot is GUARD_CYCLES all-off cycles followed by REFRESH_DIV lit cycles.
// Optional feature macro: HEX_SCAN_LZB_EN enables leading-zero blanking.
module hex_digit_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    hex_digit_scanner_if.slave bus
);
    localparam int MAX_TC = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CNT_W  = (MAX_TC > 1) ? $clog2(MAX_TC) : 1;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int VAL_W  = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {ST_GUARD, ST_SCAN} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic                  boundary;

    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d;
    logic                  fdone_q, fdone_d;

    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] suppress;
    logic                  lit;

    // Split the next display value into per-digit nibbles and leading-zero flags
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = disp_d[4*gi +: 4];
`ifdef HEX_SCAN_LZB_EN
            if (gi == 0) begin : g_d0
                assign suppress[gi] = 1'b0;
            end else begin : g_dn
                assign suppress[gi] = bus.blank_zero_i && (disp_d[VAL_W-1:4*gi] == '0);
            end
`else
            assign suppress[gi] = 1'b0;
`endif
        end
    endgenerate

    // State, counters, value registers and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_GUARD;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            disp_q    <= '0;
            nibble_q  <= 4'h0;
            sel_q     <= '0;
            blank_q   <= 1'b1;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            disp_q    <= disp_d;
            nibble_q  <= nibble_d;
            sel_q     <= sel_d;
            blank_q   <= blank_d;
            fdone_q   <= fdone_d;
        end
    end

    // Slot sequencing, frame boundary detection and shadow/commit logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        boundary  = 1'b0;
        case (state_q)
            ST_GUARD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d    = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
        endcase
        // A load on the boundary edge is not yet in shadow_q, so it waits a frame
        disp_d    = (boundary && pending_q) ? shadow_q : disp_q;
        shadow_d  = bus.load_en_i ? bus.value_i : shadow_q;
        pending_d = bus.load_en_i ? 1'b1 : (boundary ? 1'b0 : pending_q);
    end

    // Outputs computed from next state so registered outputs line up with the state
    always_comb begin
        lit      = (state_d == ST_SCAN) && !suppress[idx_d];
        nibble_d = nib_arr[idx_d];
        sel_d    = lit ? (NUM_DIGITS'(1) << idx_d) : '0;
        blank_d  = !lit;
        fdone_d  = boundary;
    end

    assign bus.nibble_o      = nibble_q;
    assign bus.digit_sel_o   = sel_q;
    assign bus.digit_blank_o = blank_q;
    assign bus.frame_done_o  = fdone_q;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Randomized bench for hex_digit_scanner with a frame-arithmetic reference model.
// Build with HEX_SCAN_LZB_EN defined to also exercise leading-zero blanking.
module tb_hex_digit_scanner;
    localparam int ND    = 4;
    localparam int RD    = 4;
    localparam int GC    = 1;
    localparam int SLOT  = GC + RD;
    localparam int FRAME = ND * SLOT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex_digit_scanner_if #(.NUM_DIGITS(ND)) bus ();

    hex_digit_scanner #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: k = clock edges since reset release
    int          k = 0;
    logic [15:0] m_disp = '0, m_shadow = '0;
    bit          m_pend = 0;
    bit          m_bz = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    // Reference model update on each edge, then check all outputs
    always begin
        int p, d;
        bit lit;
        logic [3:0] e_nib;
        logic [ND-1:0] e_sel;
        bit e_fd;
        @(posedge clk);
        if (rst) begin
            k = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_bz = 0;
        end else begin
            if (((k + 1) % FRAME) == 0 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 0;
            end
            if (bus.load_en_i) begin
                m_shadow = bus.value_i;
                m_pend   = 1;
            end
`ifdef HEX_SCAN_LZB_EN
            m_bz = bus.blank_zero_i;
`endif
            k = k + 1;
        end
        #1;
        p     = k % FRAME;
        d     = p / SLOT;
        lit   = (p % SLOT) >= GC;
        if (m_bz && d > 0 && (m_disp >> (4 * d)) == 0) lit = 0;
        e_nib = 4'((m_disp >> (4 * d)) & 16'hF);
        e_sel = lit ? ND'(1 << d) : '0;
        e_fd  = (k > 0) && (p == 0);
        chk("digit_sel",   32'(bus.digit_sel_o),   32'(e_sel));
        chk("digit_blank", 32'(bus.digit_blank_o), 32'(!lit));
        chk("nibble",      32'(bus.nibble_o),      32'(e_nib));
        chk("frame_done",  32'(bus.frame_done_o),  32'(e_fd));
    end

    task automatic wait_k(input int target);
        int n = 0;
        while (k != target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_k_timeout", 32'(k), 32'(target));
    endtask

    task automatic wait_mod(input int m);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((k % FRAME) != m && n < 200);
        chk("wait_mod_timeout", 32'(k % FRAME), 32'(m));
    endtask

    // drive a single-cycle load that the DUT samples at edge e
    task automatic load_at(input int e, input logic [15:0] v);
        wait_k(e - 1);
        bus.load_en_i = 1'b1;
        bus.value_i   = v;
        $display("load %h sampled at edge %0d", v, e);
        wait_k(e);
        bus.load_en_i = 1'b0;
    endtask

    // hand-computed expectations for the first frame
    logic [3:0] sel_first [FRAME] = '{0,1,1,1,1, 0,2,2,2,2, 0,4,4,4,4, 0,8,8,8,8};

    initial begin
        int b;
        bus.value_i   = '0;
        bus.load_en_i = 1'b0;
`ifdef HEX_SCAN_LZB_EN
        bus.blank_zero_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_sel",   32'(bus.digit_sel_o),   32'h0);
        chk("rst_blank", 32'(bus.digit_blank_o), 32'h1);
        chk("rst_nib",   32'(bus.nibble_o),      32'h0);
        chk("rst_fd",    32'(bus.frame_done_o),  32'h0);
        rst = 1'b0;
        $display("reset released");

        // first frame digit pattern and first Frame_Done
        for (int j = 0; j < FRAME; j++) begin
            wait_k(j);
            chk("first_frame_sel", 32'(bus.digit_sel_o), 32'(sel_first[j]));
        end
        wait_k(20);
        chk("first_frame_done", 32'(bus.frame_done_o), 32'h1);

        // mid-frame load commits at the following boundary
        load_at(25, 16'hA5C3);
        wait_k(36); chk("a5c3_still_old", 32'(bus.nibble_o), 32'h0);
        wait_k(41); chk("a5c3_d0", 32'(bus.nibble_o), 32'h3);
        wait_k(46); chk("a5c3_d1", 32'(bus.nibble_o), 32'hC);
        wait_k(51); chk("a5c3_d2", 32'(bus.nibble_o), 32'h5);
        wait_k(56); chk("a5c3_d3", 32'(bus.nibble_o), 32'hA);
        wait_k(60); chk("frame_done_60", 32'(bus.frame_done_o), 32'h1);

        // last load in a frame wins
        load_at(62, 16'h1234);
        load_at(70, 16'hBEEF);
        wait_k(81); chk("beef_d0", 32'(bus.nibble_o), 32'hF);
        wait_k(86); chk("beef_d1", 32'(bus.nibble_o), 32'hE);
        wait_k(91); chk("beef_d2", 32'(bus.nibble_o), 32'hE);
        wait_k(96); chk("beef_d3", 32'(bus.nibble_o), 32'hB);

        // load on the boundary edge waits one more frame
        load_at(100, 16'h00F0);
        wait_k(101); chk("bnd_prev_d0", 32'(bus.nibble_o), 32'hF);
        wait_k(106); chk("bnd_prev_d1", 32'(bus.nibble_o), 32'hE);
        wait_k(121); chk("bnd_new_d0", 32'(bus.nibble_o), 32'h0);
        wait_k(126); chk("bnd_new_d1", 32'(bus.nibble_o), 32'hF);

        // randomized loads
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            bus.load_en_i = ($urandom_range(0, 7) == 0);
            bus.value_i   = 16'($urandom);
`ifdef HEX_SCAN_LZB_EN
            if ($urandom_range(0, 39) == 0) bus.blank_zero_i = 1'($urandom);
`endif
            if (bus.load_en_i) $display("random load %h before edge %0d", bus.value_i, k + 1);
        end
        @(negedge clk);
        bus.load_en_i = 1'b0;
`ifdef HEX_SCAN_LZB_EN
        bus.blank_zero_i = 1'b0;
`endif

        // reset during digit 2 scan discards a pending value
        wait_mod(3);
        bus.load_en_i = 1'b1;
        bus.value_i   = 16'h9999;
        @(negedge clk);
        bus.load_en_i = 1'b0;
        wait_mod(12);
        chk("pre_rst_sel", 32'(bus.digit_sel_o), 32'h4);
        rst = 1'b1;
        $display("reset asserted mid-scan at k=%0d", k);
        #1;
        chk("midrst_sel",   32'(bus.digit_sel_o),   32'h0);
        chk("midrst_blank", 32'(bus.digit_blank_o), 32'h1);
        chk("midrst_nib",   32'(bus.nibble_o),      32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_k(1);  chk("restart_sel", 32'(bus.digit_sel_o), 32'h1);
        wait_k(16); chk("restart_sel3", 32'(bus.digit_sel_o), 32'h8);
        wait_k(21); chk("pending_discarded", 32'(bus.nibble_o), 32'h0);

`ifdef HEX_SCAN_LZB_EN
        // leading-zero blanking
        wait_k(24);
        bus.blank_zero_i = 1'b1;
        load_at(26, 16'h0070);
        b = 40;
        wait_k(b + 1);  chk("lzb_d0_sel", 32'(bus.digit_sel_o), 32'h1);
        chk("lzb_d0_nib", 32'(bus.nibble_o), 32'h0);
        wait_k(b + 6);  chk("lzb_d1_sel", 32'(bus.digit_sel_o), 32'h2);
        chk("lzb_d1_nib", 32'(bus.nibble_o), 32'h7);
        wait_k(b + 11); chk("lzb_d2_sel", 32'(bus.digit_sel_o), 32'h0);
        chk("lzb_d2_blank", 32'(bus.digit_blank_o), 32'h1);
        wait_k(b + 16); chk("lzb_d3_sel", 32'(bus.digit_sel_o), 32'h0);
        load_at(b + 17, 16'h0000);
        b = 60;
        wait_k(b + 1);  chk("lzb0_d0_sel", 32'(bus.digit_sel_o), 32'h1);
        wait_k(b + 6);  chk("lzb0_d1_sel", 32'(bus.digit_sel_o), 32'h0);
        chk("lzb0_d1_blank", 32'(bus.digit_blank_o), 32'h1);
        wait_k(b + 20); chk("lzb0_fd", 32'(bus.frame_done_o), 32'h1);
        bus.blank_zero_i = 1'b0;
`else
        b = 0;
`endif
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1);
    end
endmodule
